// File: rtl/class_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : class_pkg
//  Purpose  : Shared definitions for the 4-bit number-class sequence
//             generator: class membership masks, class-select encodings,
//             the generator FSM state type and a mask lookup helper.
//  Contents : PRIME_MASK, DIV3_MASK  - bit n set when value n is a member
//             CLS_PRIME, CLS_DIV3    - values of the class-select input
//             COUNT_MAX              - saturation value of the 3-bit count
//             cls_state_t            - IDLE / SCAN / EMIT / DONE
//             class_bit()            - returns mask[value]
//  Revision : 1.0 - initial release
// ============================================================================
package class_pkg;

    // Bit n of each mask is 1 when value n belongs to the class.
    // Primes: 2, 3, 5, 7, 11, 13.  Multiples of 3: 0, 3, 6, 9, 12, 15.
    localparam logic [15:0] PRIME_MASK = 16'h28AC;
    localparam logic [15:0] DIV3_MASK  = 16'h9249;

    localparam logic CLS_PRIME = 1'b0;
    localparam logic CLS_DIV3  = 1'b1;

    localparam logic [2:0] COUNT_MAX = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } cls_state_t;

    function automatic logic class_bit(input logic [15:0] mask,
                                       input logic [3:0]  value);
        return mask[value];
    endfunction

endpackage
`default_nettype wire

// File: rtl/class_lookup.sv
`default_nettype none
// ============================================================================
//  Module   : class_lookup
//  Purpose  : Combinational class-membership test for a 4-bit value, driven
//             from the class_pkg masks. Matches the classifier equations:
//             prime = {2,3,5,7,11,13}, multiple of 3 = {0,3,6,9,12,15}.
//  Ports    : val    [3:0] in  - value under test
//             sel          in  - 0 = prime, 1 = multiple of 3
//             member       out - 1 when val belongs to the selected class
//  Revision : 1.0 - initial release
// ============================================================================
module class_lookup (
    input  logic [3:0] val,
    input  logic       sel,
    output logic       member
);
    import class_pkg::*;

    always_comb begin
        member = 1'b0;
        case (sel)
            CLS_PRIME: member = class_bit(PRIME_MASK, val);
            CLS_DIV3:  member = class_bit(DIV3_MASK, val);
            default:   member = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/class_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module   : class_seq_gen
//  Purpose  : Scans the 4-bit range 0..LAST and streams every member of the
//             selected class (prime or multiple of 3) over valid/ready.
//             Non-members cost one SCAN cycle; members cost one SCAN cycle
//             plus one EMIT cycle per stall-free handshake.
//  Params   : LAST         - inclusive scan upper bound, 0..15 (default 15)
//  Macro    : CLASS_SEQ_DESCEND_EN - when defined, scan runs LAST down to 0
//             and values are emitted in descending order. Ports unchanged.
//  Ports    : clk          in      - rising-edge clock
//             rst          in      - synchronous active-high reset
//             start        in      - begin a scan (honoured only in IDLE)
//             sel          in      - class select captured with start
//             out_ready    in      - consumer accepts out_data
//             out_valid    out     - out_data holds a class member
//             out_data     out [3] - emitted value
//             busy         out     - high in SCAN and EMIT
//             done         out     - one-cycle pulse at end of scan
//             count        out [2] - values accepted in current/last scan
//  Revision : 1.0 - initial release
// ============================================================================
module class_seq_gen #(
    parameter int unsigned LAST = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       sel,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] out_data,
    output logic       busy,
    output logic       done,
    output logic [2:0] count
);
    import class_pkg::*;

    localparam logic [3:0] LAST_V = 4'(LAST);

`ifdef CLASS_SEQ_DESCEND_EN
    localparam logic [3:0] SCAN_START = LAST_V;
    localparam logic [3:0] SCAN_END   = 4'd0;
`else
    localparam logic [3:0] SCAN_START = 4'd0;
    localparam logic [3:0] SCAN_END   = LAST_V;
`endif

    cls_state_t state_q, state_d;
    logic [3:0] idx_q,   idx_d;
    logic       sel_q,   sel_d;
    logic [2:0] count_q, count_d;

    logic       is_member;
    logic       at_end;
    logic [3:0] idx_step;

    class_lookup u_lookup (
        .val    (idx_q),
        .sel    (sel_q),
        .member (is_member)
    );

    assign at_end = (idx_q == SCAN_END);

`ifdef CLASS_SEQ_DESCEND_EN
    assign idx_step = idx_q - 4'd1;
`else
    assign idx_step = idx_q + 4'd1;
`endif

    // ------------------------------------------------------------------
    // Next-state and datapath update. The end-of-range test is checked
    // before stepping so idx never wraps past the scan end.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        count_d = count_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sel_d   = sel;
                    idx_d   = SCAN_START;
                    count_d = 3'd0;
                    state_d = SCAN;
                end
            end

            SCAN: begin
                if (is_member) begin
                    state_d = EMIT;
                end else if (at_end) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_step;
                end
            end

            EMIT: begin
                if (out_ready) begin
                    if (count_q != COUNT_MAX) begin
                        count_d = count_q + 3'd1;
                    end
                    if (at_end) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_step;
                        state_d = SCAN;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            sel_q   <= 1'b0;
            count_q <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            count_q <= count_d;
        end
    end

    // Outputs come straight from registers or a decode of the state, so
    // nothing combinational from the inputs reaches the ports. idx is held
    // throughout EMIT, which keeps out_data stable under backpressure.
    assign out_valid = (state_q == EMIT);
    assign out_data  = idx_q;
    assign busy      = (state_q == SCAN) || (state_q == EMIT);
    assign done      = (state_q == DONE);
    assign count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_class_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_class_seq_gen
//  Purpose  : Directed self-checking bench for class_seq_gen. Two instances:
//             u_dut with LAST = 15 and u_dut10 with LAST = 10. Expected
//             streams follow CLASS_SEQ_DESCEND_EN when it is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_class_seq_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start10;
    logic       sel;
    logic       out_ready;

    logic       v0, v10;
    logic [3:0] d0, d10;
    logic       b0, b10;
    logic       dn0, dn10;
    logic [2:0] c0, c10;

    int n_checks = 0;
    int n_pass   = 0;

    // Results of the most recent run_scan.
    int got_q[$];
    int first_valid;
    int done_at;
    int hold_seen;
    int cnt_at_done;
    int busy_at_done;

    always #5 clk = ~clk;

    class_seq_gen u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sel       (sel),
        .out_ready (out_ready),
        .out_valid (v0),
        .out_data  (d0),
        .busy      (b0),
        .done      (dn0),
        .count     (c0)
    );

    class_seq_gen #(.LAST(10)) u_dut10 (
        .clk       (clk),
        .rst       (rst),
        .start     (start10),
        .sel       (sel),
        .out_ready (out_ready),
        .out_valid (v10),
        .out_data  (d10),
        .busy      (b10),
        .done      (dn10),
        .count     (c10)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_stream(input string tag, input int exp_q[$]);
        check({tag, " length"}, got_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            check($sformatf("%s[%0d]", tag, i),
                  (i < got_q.size()) ? got_q[i] : -1, exp_q[i]);
        end
    endtask

    // Starts a scan and consumes the stream. Samples are taken on the
    // falling edge; sample j reflects the state after rising edge t_j,
    // where t_0 is the edge that captures start. Value stall_val is refused
    // stall_n times before it is accepted. With toggle set, start and sel
    // are wiggled while the scan is in progress.
    task automatic run_scan(input bit use10, input logic s, input int stall_val,
                            input int stall_n, input bit toggle, input int budget);
        int   stalls;
        logic v, dn, b;
        logic [3:0] d;
        logic [2:0] c;
        got_q.delete();
        first_valid  = -1;
        done_at      = -1;
        hold_seen    = 0;
        cnt_at_done  = -1;
        busy_at_done = -1;
        stalls       = 0;
        @(negedge clk);
        if (use10) start10 = 1'b1; else start = 1'b1;
        sel       = s;
        out_ready = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        start10 = 1'b0;
        for (int j = 0; j < budget; j++) begin
            v  = use10 ? v10  : v0;
            d  = use10 ? d10  : d0;
            dn = use10 ? dn10 : dn0;
            b  = use10 ? b10  : b0;
            c  = use10 ? c10  : c0;
            if (v && first_valid < 0) first_valid = j;
            if (v && int'(d) == stall_val) hold_seen++;
            if (dn) begin
                done_at      = j;
                cnt_at_done  = int'(c);
                busy_at_done = int'(b);
                break;
            end
            if (v) begin
                if (int'(d) == stall_val && stalls < stall_n) begin
                    out_ready = 1'b0;
                    stalls++;
                end else begin
                    out_ready = 1'b1;
                    got_q.push_back(int'(d));
                end
            end else begin
                out_ready = 1'b1;
            end
            if (toggle && j >= 2 && j <= 10) begin
                if (use10) start10 = j[0]; else start = j[0];
                sel = ~s;
            end else begin
                start   = 1'b0;
                start10 = 1'b0;
                sel     = s;
            end
            @(negedge clk);
        end
        start     = 1'b0;
        start10   = 1'b0;
        out_ready = 1'b1;
        if (done_at < 0) check("scan timeout", 0, 1);
        @(negedge clk);
    endtask

    int exp_prime[$];
    int exp_div3[$];
    int exp_prime10[$];
    int saw_done;
    int waited;

    initial begin
`ifdef CLASS_SEQ_DESCEND_EN
        exp_prime   = '{13, 11, 7, 5, 3, 2};
        exp_div3    = '{15, 12, 9, 6, 3, 0};
        exp_prime10 = '{7, 5, 3, 2};
`else
        exp_prime   = '{2, 3, 5, 7, 11, 13};
        exp_div3    = '{0, 3, 6, 9, 12, 15};
        exp_prime10 = '{2, 3, 5, 7};
`endif
        rst       = 1'b1;
        start     = 1'b0;
        start10   = 1'b0;
        sel       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst out_valid", int'(v0), 0);
        check("rst out_data",  int'(d0), 0);
        check("rst busy",      int'(b0), 0);
        check("rst done",      int'(dn0), 0);
        check("rst count",     int'(c0), 0);
        rst = 1'b0;
        @(negedge clk);

        // Primes, no backpressure: 16 SCAN + 6 EMIT cycles, DONE after t22
        run_scan(1'b0, 1'b0, -1, 0, 1'b0, 60);
        check_stream("prime", exp_prime);
        check("prime first valid", first_valid, 3);
        check("prime done cycle",  done_at, 22);
        check("prime count",       cnt_at_done, 6);
        check("prime busy@done",   busy_at_done, 0);
        check("prime count hold",  int'(c0), 6);
        check("prime done pulse",  int'(dn0), 0);

        // Multiples of 3
        run_scan(1'b0, 1'b1, -1, 0, 1'b0, 60);
        check_stream("div3", exp_div3);
        check("div3 first valid", first_valid, 1);
        check("div3 done cycle",  done_at, 22);
        check("div3 count",       cnt_at_done, 6);

        // Backpressure on 5: six samples of 5 (five refused plus accept)
        run_scan(1'b0, 1'b0, 5, 5, 1'b0, 80);
        check_stream("stall", exp_prime);
        check("stall hold 5", hold_seen, 6);
        check("stall count",  cnt_at_done, 6);

        // LAST = 10: 11 SCAN + 4 EMIT cycles
        run_scan(1'b1, 1'b0, -1, 0, 1'b0, 60);
        check_stream("last10", exp_prime10);
        check("last10 done cycle", done_at, 15);
        check("last10 count",      cnt_at_done, 4);

        // start/sel wiggled mid-scan: stream unaffected
        run_scan(1'b0, 1'b1, -1, 0, 1'b1, 60);
        check_stream("toggle", exp_div3);
        check("toggle count", cnt_at_done, 6);

        // Reset during EMIT of 7
        @(negedge clk);
        start     = 1'b1;
        sel       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        waited = 0;
        while (!(v0 && d0 == 4'd7) && waited < 40) begin
            out_ready = !(v0 && d0 == 4'd7);
            @(negedge clk);
            waited++;
            if (v0 && d0 == 4'd7) out_ready = 1'b0;
        end
        check("rst-mid reached 7", int'(v0 && d0 == 4'd7), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        check("rst-mid out_valid", int'(v0), 0);
        check("rst-mid count",     int'(c0), 0);
        check("rst-mid busy",      int'(b0), 0);
        saw_done = 0;
        for (int k = 0; k < 6; k++) begin
            if (dn0) saw_done = 1;
            @(negedge clk);
        end
        check("rst-mid no done", saw_done, 0);
        check("rst-mid idle",    int'(b0), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
